// File: rtl/mem_ctrl_pkg.sv
// Shared widths, op encodings and state type for the memory access controller.
// The verify states exist only when MEM_ACCESS_CTRL_VERIFY_EN is defined.
package mem_ctrl_pkg;

    localparam int   ADDR_W   = 3;
    localparam int   DATA_W   = 8;
    localparam int   CNT_W    = 4;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RELEASE = 3'd3
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        ,
        ST_VSETUP   = 3'd4,
        ST_VACCESS  = 3'd5,
        ST_VRELEASE = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/mem_access_timer.sv
// Load/decrement cycle counter; o_done marks the final cycle of an access window.
module mem_access_timer
    import mem_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word memory access sequencer: SETUP / ACCESS / RELEASE around a select strobe.
// Define MEM_ACCESS_CTRL_VERIFY_EN to add a read-back verify pass after every write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_mem_adr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_op,
    output logic              o_mem_select,
    input  logic [DATA_W-1:0] i_mem_data
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

    state_t            r_state;
    logic              r_we;
    logic              r_busy;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_op;
    logic              r_mem_select;
    logic              w_load;
    logic              w_dec;
    logic              w_done;

    // Counter is loaded during the setup cycle so the first access cycle sees ACCESS_CYCLES-1.
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    logic r_err;
    assign w_load = (r_state == ST_SETUP) || (r_state == ST_VSETUP);
    assign w_dec  = ((r_state == ST_ACCESS) || (r_state == ST_VACCESS)) && !w_done;
`else
    assign w_load = (r_state == ST_SETUP);
    assign w_dec  = (r_state == ST_ACCESS) && !w_done;
`endif

    mem_access_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_done     (w_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_mem_adr    <= '0;
            r_mem_data   <= '0;
            r_mem_op     <= 1'b0;
            r_mem_select <= 1'b0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Memory pins take the request directly so they settle during SETUP.
                    if (i_req) begin
                        r_we       <= i_we;
                        r_mem_adr  <= i_addr;
                        r_mem_data <= i_wdata;
                        r_mem_op   <= i_we;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_mem_select <= 1'b1;
                    r_state      <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_mem_select <= 1'b0;
                        if (r_we == OP_READ) begin
                            r_rdata <= i_mem_data;
                        end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                        r_ack <= (r_we == OP_READ);
`else
                        r_ack <= 1'b1;
`endif
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                    if (r_we == OP_WRITE) begin
                        r_mem_op <= OP_READ;
                        r_state  <= ST_VSETUP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`endif
                end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                ST_VSETUP: begin
                    r_mem_select <= 1'b1;
                    r_state      <= ST_VACCESS;
                end
                ST_VACCESS: begin
                    // r_mem_data still holds the written word and is the compare reference.
                    if (w_done) begin
                        r_mem_select <= 1'b0;
                        r_ack        <= 1'b1;
                        r_err        <= (i_mem_data != r_mem_data);
                        r_state      <= ST_VRELEASE;
                    end
                end
                ST_VRELEASE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_mem_select <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_ack        = r_ack;
    assign o_rdata      = r_rdata;
    assign o_mem_adr    = r_mem_adr;
    assign o_mem_data   = r_mem_data;
    assign o_mem_op     = r_mem_op;
    assign o_mem_select = r_mem_select;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (ACCESS_CYCLES 2, 1, 4) share host inputs,
// each with its own memory model and setup/hold monitor.
module tb_mem_access_ctrl;

    localparam int N_DUT = 3;
    localparam int WIN   = 16;

    function automatic int ac_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic req;
    logic we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic stuck_en;

    logic [N_DUT-1:0] busy, ack, err, mem_op, mem_sel;
    logic [7:0] rdata    [N_DUT];
    logic [2:0] mem_adr  [N_DUT];
    logic [7:0] mem_dout [N_DUT];
    logic [7:0] mem_din  [N_DUT];
    logic [7:0] mem      [N_DUT][8];
    logic [11:0] prev_bus [N_DUT];
    logic [N_DUT-1:0] prev_sel = '0;
    int viol [N_DUT] = '{0, 0, 0};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        mem_access_ctrl #(.ACCESS_CYCLES(ac_of(gi))) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_req        (req),
            .i_we         (we),
            .i_addr       (addr),
            .i_wdata      (wdata),
            .o_busy       (busy[gi]),
            .o_ack        (ack[gi]),
            .o_rdata      (rdata[gi]),
            .o_err        (err[gi]),
            .o_mem_adr    (mem_adr[gi]),
            .o_mem_data   (mem_dout[gi]),
            .o_mem_op     (mem_op[gi]),
            .o_mem_select (mem_sel[gi]),
            .i_mem_data   (mem_din[gi])
        );
    end

    // Memory models; stuck_en forces read bit 0 high.
    always @(posedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (mem_sel[i] && mem_op[i]) mem[i][mem_adr[i]] <= mem_dout[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_DUT; i++) begin
            mem_din[i] = mem[i][mem_adr[i]] | {7'd0, stuck_en};
        end
    end

    // Setup/hold monitor: address, data and op must not move while select stays high.
    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (prev_sel[i] && mem_sel[i] && (prev_bus[i] != {mem_op[i], mem_adr[i], mem_dout[i]}))
                viol[i] = viol[i] + 1;
            prev_sel[i] = mem_sel[i];
            prev_bus[i] = {mem_op[i], mem_adr[i], mem_dout[i]};
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, i, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < N_DUT; i++) begin
            check(name, i, {8'd0, busy[i], ack[i], err[i], rdata[i], mem_adr[i], mem_dout[i],
                            mem_op[i], mem_sel[i]}, 32'd0);
        end
    endtask

    // One access; optionally injects a write request to addr 5 at cycle inj_k (0 = none).
    task automatic run_op(input logic op_we, input logic [2:0] op_addr, input logic [7:0] op_wdata,
                          input logic [7:0] exp_rd, input logic exp_e, input int inj_k);
        int lat [N_DUT];
        int acks [N_DUT];
        int busy_n [N_DUT];
        int sel_n [N_DUT];
        logic [7:0] rd_at [N_DUT];
        logic err_at [N_DUT];
        int ac, exp_lat, exp_sel;
        for (int i = 0; i < N_DUT; i++) begin
            lat[i] = 0; acks[i] = 0; busy_n[i] = 0; sel_n[i] = 0; rd_at[i] = '0; err_at[i] = 1'b0;
        end
        @(negedge clk);
        req = 1'b1; we = op_we; addr = op_addr; wdata = op_wdata;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0; we = ~op_we; addr = ~op_addr; wdata = ~op_wdata;
            end
            if (k == inj_k) begin
                req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 8'hFF;
            end else if (k == inj_k + 1) begin
                req = 1'b0;
            end
            for (int i = 0; i < N_DUT; i++) begin
                if (ack[i]) begin
                    acks[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = k; rd_at[i] = rdata[i]; err_at[i] = err[i];
                    end
                end
                if (busy[i]) busy_n[i]++;
                if (mem_sel[i]) sel_n[i]++;
            end
        end
        $display("op we=%0b addr=%0d wdata=%02h inj=%0d -> dut0 lat=%0d rdata=%02h err=%0b",
                 op_we, op_addr, op_wdata, inj_k, lat[0], rd_at[0], err_at[0]);
        for (int i = 0; i < N_DUT; i++) begin
            ac = ac_of(i);
            exp_lat = 2 + ac;
            exp_sel = ac;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
            if (op_we) begin
                exp_lat = 4 + 2 * ac;
                exp_sel = 2 * ac;
            end
`endif
            check("ack_count", i, acks[i], 1);
            check("ack_latency", i, lat[i], exp_lat);
            check("busy_cycles", i, busy_n[i], exp_lat);
            check("select_cycles", i, sel_n[i], exp_sel);
            check("err_at_ack", i, {31'd0, err_at[i]}, {31'd0, exp_e});
            if (!op_we) check("rdata_at_ack", i, {24'd0, rd_at[i]}, {24'd0, exp_rd});
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int a1 [N_DUT];
        int a2 [N_DUT];
        int na [N_DUT];
        int exp1 [N_DUT] = '{4, 3, 6};
        int exp2 [N_DUT] = '{9, 7, 0};

        vecs = '{
            '{1'b1, 3'd3, 8'hA5, 8'h00, 1'b0},
            '{1'b0, 3'd3, 8'h00, 8'hA5, 1'b0},
            '{1'b1, 3'd0, 8'h11, 8'h00, 1'b0},
            '{1'b1, 3'd1, 8'h22, 8'h00, 1'b0},
            '{1'b1, 3'd2, 8'h33, 8'h00, 1'b0},
            '{1'b1, 3'd3, 8'h44, 8'h00, 1'b0},
            '{1'b1, 3'd4, 8'h55, 8'h00, 1'b0},
            '{1'b1, 3'd5, 8'h66, 8'h00, 1'b0},
            '{1'b1, 3'd6, 8'h77, 8'h00, 1'b0},
            '{1'b1, 3'd7, 8'h88, 8'h00, 1'b0},
            '{1'b0, 3'd7, 8'h00, 8'h88, 1'b0},
            '{1'b0, 3'd6, 8'h00, 8'h77, 1'b0},
            '{1'b0, 3'd5, 8'h00, 8'h66, 1'b0},
            '{1'b0, 3'd4, 8'h00, 8'h55, 1'b0},
            '{1'b0, 3'd3, 8'h00, 8'h44, 1'b0},
            '{1'b0, 3'd2, 8'h00, 8'h33, 1'b0},
            '{1'b0, 3'd1, 8'h00, 8'h22, 1'b0},
            '{1'b0, 3'd0, 8'h00, 8'h11, 1'b0}
        };

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; stuck_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;

        for (int v = 0; v < 18; v++) begin
            run_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd, vecs[v].exp_err, 0);
        end

        // Request during ACCESS is dropped; addr 5 keeps its old contents.
        run_op(1'b0, 3'd2, 8'h00, 8'h33, 1'b0, 2);
        run_op(1'b0, 3'd5, 8'h00, 8'h66, 1'b0, 0);

        // Request held through RELEASE is taken in the following IDLE cycle.
        for (int i = 0; i < N_DUT; i++) begin a1[i] = 0; a2[i] = 0; na[i] = 0; end
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 3'd3;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (k == 6) req = 1'b0;
            for (int i = 0; i < N_DUT; i++) begin
                if (ack[i]) begin
                    na[i]++;
                    if (na[i] == 1) a1[i] = k;
                    if (na[i] == 2) a2[i] = k;
                end
            end
        end
        $display("held request -> dut0 acks at %0d and %0d", a1[0], a2[0]);
        for (int i = 0; i < N_DUT; i++) begin
            check("held_req_ack1", i, a1[i], exp1[i]);
            check("held_req_ack2", i, a2[i], exp2[i]);
            check("held_req_count", i, na[i], (exp2[i] != 0) ? 2 : 1);
        end

        // Reset in the first ACCESS cycle of a write to addr 6.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd6; wdata = 8'hE6;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) check("select_before_reset", i, {31'd0, mem_sel[i]}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("mid_access_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_DUT; i++) na[i] = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            for (int i = 0; i < N_DUT; i++) if (ack[i] || mem_sel[i]) na[i]++;
        end
        $display("reset abort -> dut0 ack/select cycles after reset=%0d", na[0]);
        for (int i = 0; i < N_DUT; i++) check("no_ack_after_abort", i, na[i], 0);
        run_op(1'b0, 3'd6, 8'h00, 8'h77, 1'b0, 0);

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        stuck_en = 1'b1;
        run_op(1'b1, 3'd7, 8'h3C, 8'h00, 1'b1, 0);
        stuck_en = 1'b0;
        run_op(1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 0);
        run_op(1'b0, 3'd7, 8'h00, 8'h5A, 1'b0, 0);
`endif

        for (int i = 0; i < N_DUT; i++) check("setup_hold_violations", i, viol[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
